// File: rtl/pipe_issue_sched.sv
// In-order issue scheduler: instruction FIFO, per-register pending scoreboard, illegal-func filter.
// Define PIPE_PERF_CNT_EN to add the stall_cnt/issue_cnt performance counters.
module pipe_issue_sched #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3,
    parameter int NREG   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    input  logic        flush,
    output logic        iss_valid,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_addr,
    output logic        busy,
    output logic        illegal
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] issue_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL, S_FLUSH} state_t;

    instr_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_pend [NREG];
    state_t          r_state, w_state_nxt;
    logic            r_iss_valid, r_illegal;
    instr_t          r_iss;

    logic   w_full, w_empty, w_hazard, w_accept, w_legal, w_push, w_pop, w_any_pend;
    instr_t w_head;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_hazard = !w_empty && ((r_pend[w_head.rs1] != 2'd0) || (r_pend[w_head.rs2] != 2'd0));
    assign w_accept = in_valid && !w_full;
    assign w_legal  = (in_func <= 4'd11);
    // flush wins over a concurrent push; the FIFO is always empty while in FLUSH
    assign w_push   = w_accept && w_legal && !flush;
    assign w_pop    = !flush && (r_state != S_FLUSH) && !w_empty && !w_hazard;

    always_comb begin
        w_any_pend = 1'b0;
        for (int i = 0; i < NREG; i++) w_any_pend = w_any_pend | (r_pend[i] != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= instr_t'({in_rs1, in_rs2, in_rd, in_func, in_addr});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Scoreboard keeps counting down through flush so in-flight writebacks still gate readers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_pop && (w_head.rd == 4'(i))) r_pend[i] <= 2'(WB_LAT);
                else if (r_pend[i] != 2'd0)        r_pend[i] <= r_pend[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_iss_valid <= w_pop;
            if (w_pop) r_iss <= w_head;
            r_illegal   <= w_accept && !w_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
                S_ISSUE: if (w_empty) w_state_nxt = S_IDLE;
                         else if (w_hazard) w_state_nxt = S_STALL;
                S_STALL: if (!w_hazard) w_state_nxt = S_ISSUE;
                S_FLUSH: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cnt, r_issue_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if ((r_state == S_STALL) && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (r_iss_valid && (r_issue_cnt != 16'hFFFF))          r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

    assign in_ready  = !w_full;
    assign busy      = !w_empty || w_any_pend;
    assign illegal   = r_illegal;
    assign iss_valid = r_iss_valid;
    assign iss_rs1   = r_iss.rs1;
    assign iss_rs2   = r_iss.rs2;
    assign iss_rd    = r_iss.rd;
    assign iss_func  = r_iss.func;
    assign iss_addr  = r_iss.addr;
endmodule

// File: tb/tb_pipe_issue_sched.sv
// Bench for pipe_issue_sched: queue/array reference model compared every cycle, plus directed scenarios.
module tb_pipe_issue_sched;
    localparam int DEPTH  = 4;
    localparam int WB_LAT = 3;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    logic clk, rst_n, in_valid, in_ready, flush, iss_valid, busy, illegal;
    logic [3:0] in_rs1, in_rs2, in_rd, in_func, iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] in_addr, iss_addr;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt, issue_cnt;
`endif

    pipe_issue_sched #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .flush(flush), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr), .busy(busy), .illegal(illegal)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int   vectors = 0, errors = 0, cyc = 0, m_issues = 0, dut_ill = 0;
    bit   chk_en = 0;
    ins_t mq[$];
    int   mpend[16];
    bit   e_valid, e_illegal;
    ins_t e_iss;
    ins_t dq[$];
    int   dc[$];

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: queue of waiting instructions plus remaining-writeback cycles per register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            for (int r = 0; r < 16; r++) mpend[r] = 0;
            e_valid = 0; e_illegal = 0; e_iss = '0; m_issues = 0;
        end else begin
            bit acc, iss;
            acc = in_valid && (mq.size() < DEPTH);
            iss = !flush && (mq.size() > 0) && (mpend[mq[0].rs1] == 0) && (mpend[mq[0].rs2] == 0);
            for (int r = 0; r < 16; r++) if (mpend[r] > 0) mpend[r]--;
            e_valid   = iss;
            e_illegal = acc && (in_func > 11);
            if (iss) begin
                e_iss = mq.pop_front();
                mpend[e_iss.rd] = WB_LAT;
                m_issues++;
            end
            if (flush) mq.delete();
            else if (acc && in_func <= 11) mq.push_back(ins_t'({in_rs1, in_rs2, in_rd, in_func, in_addr}));
        end
    end

    always @(negedge clk) if (chk_en) begin
        bit anyp;
        anyp = 0;
        for (int r = 0; r < 16; r++) if (mpend[r] != 0) anyp = 1;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("busy", busy, (mq.size() > 0) || anyp);
        chk("iss_valid", iss_valid, e_valid);
        chk("illegal", illegal, e_illegal);
        chk("iss_rs1", iss_rs1, e_iss.rs1);
        chk("iss_rs2", iss_rs2, e_iss.rs2);
        chk("iss_rd", iss_rd, e_iss.rd);
        chk("iss_func", iss_func, e_iss.func);
        chk("iss_addr", iss_addr, e_iss.addr);
`ifdef PIPE_PERF_CNT_EN
        chk("issue_cnt", issue_cnt, (m_issues > 65535) ? 65535 : m_issues);
`endif
    end

    always @(negedge clk) begin
        if (iss_valid) begin
            dq.push_back(ins_t'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}));
            dc.push_back(cyc);
        end
        if (illegal) dut_ill++;
    end

    task automatic drive(bit v, bit f, logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd,
                         logic [3:0] fn, logic [7:0] ad);
        @(negedge clk);
        in_valid = v; flush = f;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_func = fn; in_addr = ad;
    endtask

    task automatic idle(int n);
        @(negedge clk);
        in_valid = 0; flush = 0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        int n0, c0, i0, found;
`ifdef PIPE_PERF_CNT_EN
        int s0;
`endif
        rst_n = 1; in_valid = 0; flush = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_func = 0; in_addr = 0;
        #3 rst_n = 0;
        chk_en = 1;

        // Reset holds off pushes even with in_valid asserted
        drive(1, 0, 1, 2, 3, 0, 8'h01);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_issued", dq.size(), 0);

        // Independent ops issue back to back, one cycle after push
        n0 = dq.size();
        drive(1, 0, 1, 2, 3, 0, 8'h10);
        c0 = cyc;
        drive(1, 0, 4, 5, 6, 0, 8'h11);
        drive(1, 0, 7, 8, 9, 0, 8'h12);
        idle(8);
        chk("t2_count", dq.size() - n0, 3);
        if (dq.size() - n0 == 3) begin
            chk("t2_latency", dc[n0] - c0, 2);
            for (int i = 0; i < 3; i++) begin
                chk("t2_addr", dq[n0+i].addr, 8'h10 + i);
                chk("t2_rs1", dq[n0+i].rs1, 1 + 3 * i);
            end
            for (int i = 1; i < 3; i++) chk("t2_b2b", dc[n0+i] - dc[n0+i-1], 1);
        end

        // RAW: consumer issues WB_LAT+1 cycles after producer
        n0 = dq.size();
`ifdef PIPE_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        drive(1, 0, 1, 2, 3, 0, 8'h20);
        drive(1, 0, 3, 4, 5, 0, 8'h21);
        idle(10);
        chk("t3_count", dq.size() - n0, 2);
        if (dq.size() - n0 == 2) begin
            chk("t3_gap", dc[n0+1] - dc[n0], 4);
            chk("t3_addr", dq[n0+1].addr, 8'h21);
        end
`ifdef PIPE_PERF_CNT_EN
        chk("t3_stall_cnt", stall_cnt - s0, 3);
`endif

        // Fill behind a stalled head; a fifth offer is refused
        n0 = dq.size();
        drive(1, 0, 1, 2, 3, 0, 8'h30);
        for (int i = 0; i < 4; i++) drive(1, 0, 3, 0, 4'(10 + i), 4'(i + 1), 8'(8'h31 + i));
        drive(1, 0, 0, 0, 15, 0, 8'hFF);
        chk("t4_full_ready", in_ready, 0);
        idle(12);
        chk("t4_count", dq.size() - n0, 5);
        found = 0;
        for (int i = n0; i < dq.size(); i++) if (dq[i].addr == 8'hFF) found = 1;
        chk("t4_no_fifth", found, 0);

        // Illegal func: one pulse, nothing issued
        n0 = dq.size(); i0 = dut_ill;
        drive(1, 0, 1, 1, 1, 12, 8'h50);
        idle(6);
        chk("t4_illegal_pulses", dut_ill - i0, 1);
        chk("t4_illegal_issued", dq.size() - n0, 0);

        // Flush with concurrent push behind a stall
        n0 = dq.size();
        drive(1, 0, 1, 2, 3, 0, 8'h60);
        for (int i = 0; i < 3; i++) drive(1, 0, 3, 0, 4'(11 + i), 0, 8'(8'h61 + i));
        drive(1, 1, 0, 0, 14, 0, 8'hEE);
        idle(1);
        chk("t5_no_issue_on_flush", iss_valid, 0);
        idle(8);
        chk("t5_count", dq.size() - n0, 1);
        chk("t5_busy_drained", busy, 0);

        // Ten independent ops through a 4-deep FIFO
        n0 = dq.size();
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 4'(1 + i), 4'(i), 8'(8'h70 + i));
        idle(8);
        chk("t6_count", dq.size() - n0, 10);
        if (dq.size() - n0 == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("t6_addr", dq[n0+i].addr, 8'h70 + i);
                chk("t6_rd", dq[n0+i].rd, 1 + i);
                chk("t6_func", dq[n0+i].func, i);
            end
            for (int i = 1; i < 10; i++) chk("t6_b2b", dc[n0+i] - dc[n0+i-1], 1);
        end

        // Random traffic with occasional flush and one mid-run reset
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 9) < 6);
            in_rs1   = 4'($urandom_range(0, 7));
            in_rs2   = 4'($urandom_range(0, 7));
            in_rd    = 4'($urandom_range(0, 7));
            in_func  = 4'($urandom_range(0, 13));
            in_addr  = 8'($urandom);
            flush    = ($urandom_range(0, 39) == 0);
            if (k == 400) #2 rst_n = 0;
            if (k == 403) rst_n = 1;
        end
        idle(10);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
